// File: rtl/i281_uart_pkg.sv
// Shared types and constants for the i281 data-memory UART dump.
// Frame count depends on I281_DUMP_CHECKSUM_EN (adds one XOR checksum frame).
package i281_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_BITS,
    STOP_BIT,
    FINISH
  } uart_state_e;

  typedef enum logic [1:0] {
    DUMP_IDLE,
    DUMP_SEND,
    DUMP_FINISH
  } dump_state_e;

  localparam int unsigned DMEM_BYTES          = 16;
  localparam int unsigned FRAME_BITS          = 10;
  localparam logic [7:0]  DEFAULT_HEADER_BYTE = 8'hA5;

`ifdef I281_DUMP_CHECKSUM_EN
  localparam int unsigned DUMP_FRAMES = DMEM_BYTES + 2;
`else
  localparam int unsigned DUMP_FRAMES = DMEM_BYTES + 1;
`endif

  function automatic logic [7:0] xor_bytes(input logic [8*DMEM_BYTES-1:0] v);
    logic [7:0] acc;
    acc = '0;
    for (int unsigned k = 0; k < DMEM_BYTES; k++) begin
      acc = acc ^ v[8*k +: 8];
    end
    return acc;
  endfunction

endpackage

// File: rtl/i281_uart_tx_frame.sv
// Single-byte 8N1 UART serializer, LSB first.
// ready is high while idle and in the final cycle of the stop bit, so a load then chains frames gap-free.
module i281_uart_tx_frame
  import i281_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_last;

  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign ready     = (state_q == IDLE) || ((state_q == STOP_BIT) && baud_last);
  assign tx        = tx_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (load) begin
          state_d = START_BIT;
          shift_d = data;
          bit_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START_BIT: begin
        if (baud_last) begin
          state_d = DATA_BITS;
          tx_d    = shift_q[0];
        end
      end
      DATA_BITS: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = STOP_BIT;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP_BIT: begin
        if (baud_last) begin
          if (load) begin
            state_d = START_BIT;
            shift_d = data;
            bit_d   = '0;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/i281_dmem_uart_dump.sv
// Snapshots the i281 data-memory display bytes and streams header + 16 bytes out over UART.
// Define I281_DUMP_CHECKSUM_EN to append an XOR checksum frame of the 16 snapshot bytes.
module i281_dmem_uart_dump
  import i281_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter logic [7:0]  HEADER_BYTE  = DEFAULT_HEADER_BYTE
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] datamem_flat,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  dump_state_e  state_q, state_d;
  logic [4:0]   idx_q, idx_d;
  logic [127:0] snap_q, snap_d;
  logic         frame_load;
  logic [7:0]   frame_byte;
  logic         frame_ready;
  logic [3:0]   byte_sel;
  logic [7:0]   next_byte;

  i281_uart_tx_frame #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_frame (
    .clock (clock),
    .reset (reset),
    .load  (frame_load),
    .data  (frame_byte),
    .tx    (tx),
    .ready (frame_ready)
  );

  assign busy = (state_q != DUMP_IDLE);
  assign done = (state_q == DUMP_FINISH);

  // idx_q counts frames already loaded; frame n (n >= 1) carries snapshot byte n-1.
  assign byte_sel = 4'(idx_q - 5'd1);

`ifdef I281_DUMP_CHECKSUM_EN
  assign next_byte = (idx_q == 5'(DMEM_BYTES + 1)) ? xor_bytes(snap_q)
                                                    : snap_q[{byte_sel, 3'b000} +: 8];
`else
  assign next_byte = snap_q[{byte_sel, 3'b000} +: 8];
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    snap_d     = snap_q;
    frame_load = 1'b0;
    frame_byte = HEADER_BYTE;
    case (state_q)
      DUMP_IDLE: begin
        if (start) begin
          snap_d     = datamem_flat;
          frame_load = 1'b1;
          frame_byte = HEADER_BYTE;
          idx_d      = 5'd1;
          state_d    = DUMP_SEND;
        end
      end
      DUMP_SEND: begin
        if (frame_ready) begin
          if (idx_q < 5'(DUMP_FRAMES)) begin
            frame_load = 1'b1;
            frame_byte = next_byte;
            idx_d      = idx_q + 5'd1;
          end else begin
            state_d = DUMP_FINISH;
          end
        end
      end
      DUMP_FINISH: begin
        idx_d   = '0;
        state_d = DUMP_IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = DUMP_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i281_dmem_uart_dump.sv
// Directed bench for i281_dmem_uart_dump at CLKS_PER_BIT=4; models the expected tx waveform cycle by cycle.
module tb_i281_dmem_uart_dump;

  localparam int CPB = 4;
  localparam int FRAME_CYC = 10 * CPB;
`ifdef I281_DUMP_CHECKSUM_EN
  localparam int NFR = 18;
`else
  localparam int NFR = 17;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [127:0] datamem_flat = '0;
  logic         tx, busy, done;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_b [0:17];

  i281_dmem_uart_dump #(
    .CLKS_PER_BIT(CPB),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .datamem_flat (datamem_flat),
    .tx           (tx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Runs one full dump of mem, checking the tx waveform bit-accurately and decoding each frame.
  task automatic run_dump(input string tag, input logic [127:0] mem,
                          input bit mutate, input bit extra_starts);
    int total;
    int tx_err, busy_err, done_cnt, done_at, idle_err;
    int f, p, b;
    logic exp_tx;
    logic [7:0] rx [0:17];
    logic [7:0] cks;
    total = NFR * FRAME_CYC + 1;
    tx_err = 0; busy_err = 0; done_cnt = 0; done_at = -1; idle_err = 0;
    exp_b[0] = 8'hA5;
    cks = 8'h00;
    for (int k = 0; k < 16; k++) begin
      exp_b[k+1] = mem[8*k +: 8];
      cks = cks ^ mem[8*k +: 8];
    end
    exp_b[17] = cks;
    for (int k = 0; k < 18; k++) rx[k] = 8'h00;
    datamem_flat = mem;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int c = 1; c <= total; c++) begin
      if (c > 1) begin
        @(posedge clock);
        #1;
      end
      f = (c - 1) / FRAME_CYC;
      p = (c - 1) % FRAME_CYC;
      b = p / CPB;
      if (f >= NFR)    exp_tx = 1'b1;
      else if (b == 0) exp_tx = 1'b0;
      else if (b == 9) exp_tx = 1'b1;
      else             exp_tx = exp_b[f][b-1];
      if (tx !== exp_tx) tx_err++;
      if (busy !== 1'b1) busy_err++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = c;
      end
      if (f < NFR && b >= 1 && b <= 8 && (p % CPB) == CPB / 2) rx[f][b-1] = tx;
      if (mutate && c == 1) datamem_flat = {16{8'hEE}};
      start = (extra_starts && (c == 50 || c == 300)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    n_checks++;
    if (tx_err !== 0) $display("FAIL %s tx_wave: %0d mismatched cycles, required 0", tag, tx_err);
    else n_pass++;
    n_checks++;
    if (busy_err !== 0) $display("FAIL %s busy_high: %0d low cycles, required 0", tag, busy_err);
    else n_pass++;
    n_checks++;
    if (done_cnt !== 1) $display("FAIL %s done_count: got %0d required 1", tag, done_cnt);
    else n_pass++;
    n_checks++;
    if (done_at !== total) $display("FAIL %s done_cycle: got %0d required %0d", tag, done_at, total);
    else n_pass++;
    for (int k = 0; k < NFR; k++) begin
      n_checks++;
      if (rx[k] !== exp_b[k])
        $display("FAIL %s rx_byte%0d: got %02h required %02h", tag, k, rx[k], exp_b[k]);
      else n_pass++;
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1)
      $display("FAIL %s after_done: busy=%b done=%b tx=%b required 0 0 1", tag, busy, done, tx);
    else n_pass++;
    for (int c = 0; c < 30; c++) begin
      @(posedge clock);
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || tx !== 1'b1) idle_err++;
    end
    n_checks++;
    if (idle_err !== 0) $display("FAIL %s idle_after: %0d bad cycles, required 0", tag, idle_err);
    else n_pass++;
  endtask

  task automatic test_reset();
    int bad;
    bad = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_state: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL idle_100: %0d bad cycles, required 0", bad);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = 8'(k + 8'h10);
    run_dump("basic", m, 1'b0, 1'b0);
  endtask

  task automatic test_patterns();
    run_dump("zeros", {16{8'h00}}, 1'b0, 1'b0);
    run_dump("ones", {16{8'hFF}}, 1'b0, 1'b0);
  endtask

  task automatic test_snapshot();
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = 8'(8'h31 + 8'(k * 7));
    run_dump("snapshot", m, 1'b1, 1'b0);
  endtask

  task automatic test_ignored_start();
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = 8'(8'hC0 ^ k);
    run_dump("restart_ignored", m, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [127:0] m;
    int bad;
    bad = 0;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = 8'(8'h5A + k);
    datamem_flat = m;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (133) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_checks++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_mid: tx=%b busy=%b done=%b required 1 0 0", tx, busy, done);
    else n_pass++;
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock);
      #1;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL reset_mid_quiet: %0d bad cycles, required 0", bad);
    else n_pass++;
    run_dump("after_reset", m, 1'b0, 1'b0);
  endtask

  task automatic test_start_with_reset();
    @(negedge clock);
    start = 1'b1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1;
    n_checks++;
    if (busy !== 1'b0 || tx !== 1'b1)
      $display("FAIL start_reset_together: busy=%b tx=%b required 0 1", busy, tx);
    else n_pass++;
  endtask

`ifdef I281_DUMP_CHECKSUM_EN
  task automatic test_checksum();
    logic [127:0] m;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = 8'h01 << (k % 8);
    run_dump("cks_walk", m, 1'b0, 1'b0);
    n_checks++;
    if (exp_b[17] !== 8'h00) $display("FAIL cks_walk_model: got %02h required 00", exp_b[17]);
    else n_pass++;
    for (int k = 0; k < 16; k++) m[8*k +: 8] = 8'(k);
    run_dump("cks_count", m, 1'b0, 1'b0);
    m = '0;
    m[8*3 +: 8] = 8'h5A;
    run_dump("cks_single", m, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_snapshot();
    test_ignored_start();
    test_reset_mid();
    test_start_with_reset();
`ifdef I281_DUMP_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
